// File: rtl/os_checker_multilane_if.sv
// Ordered-set checker bus: extractor-side inputs and LTSSM-side status.
interface os_checker_multilane_if #(
  parameter int LANES = 4,
  parameter int CNT_W = 5
);
  logic [3:0]                  substate;
  logic [7:0]                  linkNumber;
  logic [LANES-1:0][7:0]       laneNumbers;
  logic [LANES-1:0][127:0]     orderedset;
  logic [LANES-1:0]            valid;
  logic [LANES-1:0]            lane_enable;
  logic [LANES-1:0][CNT_W-1:0] lane_cnt;
  logic [LANES-1:0]            lane_done;
  logic                        all_done;
  logic [7:0]                  rateid;
  logic                        upconfigure_capability;
  logic [LANES-1:0][7:0]       mismatch_cnt;

  modport master (
    output substate, linkNumber, laneNumbers, orderedset, valid, lane_enable,
    input  lane_cnt, lane_done, all_done, rateid, upconfigure_capability, mismatch_cnt
  );

  modport slave (
    input  substate, linkNumber, laneNumbers, orderedset, valid, lane_enable,
    output lane_cnt, lane_done, all_done, rateid, upconfigure_capability, mismatch_cnt
  );
endinterface

// File: rtl/os_checker_multilane.sv
// Multi-lane TS1/TS2/Idle ordered-set checker feeding the LTSSM.
// Optional per-lane mismatch statistics enabled by OSC_MISMATCH_STATS_EN.
module os_checker_lane #(
  parameter int DEVICETYPE = 0,
  parameter int CNT_W      = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       i_substate,
  input  logic             i_sub_chg,
  input  logic [7:0]       i_link_num,
  input  logic [7:0]       i_lane_num,
  input  logic [127:0]     i_os,
  input  logic             i_valid,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_cnt,
  output logic [7:0]       o_mism
);
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] TS1 = 8'h2A;
  localparam logic [7:0] TS2 = 8'h25;

  logic [7:0] w_link, w_lane, w_id, w_rate, w_sym0;
  logic       w_up, w_b43;
  logic       w_match, w_in_range, w_chk8, w_cons_ok, w_unused;

  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_rate;
  logic             r_up;
  logic             r_hist_vld;

  assign w_sym0   = i_os[7:0];
  assign w_link   = i_os[15:8];
  assign w_lane   = i_os[23:16];
  assign w_rate   = i_os[39:32];
  assign w_up     = i_os[42];
  assign w_b43    = i_os[43];
  assign w_id     = i_os[87:80];
  assign w_unused = ^{i_os[127:88], i_os[79:44], i_os[41:40], i_os[31:24]};

  always_comb begin
    w_match    = 1'b0;
    w_in_range = 1'b1;
    w_chk8     = 1'b0;
    case (i_substate)
      4'd2: w_match = (w_link == PAD) && (w_lane == PAD) &&
                      ((w_id == TS2) || ((w_id == TS1) && (!w_b43 || w_up)));
      4'd3: w_match = (w_link == PAD) && (w_lane == PAD) && (w_id == TS2);
      4'd4: w_match = (DEVICETYPE == 0) ?
                      ((w_link == i_link_num) && (w_lane == PAD) && (w_id == TS1)) :
                      ((w_link != PAD) && (w_lane == PAD) && (w_id == TS1));
      4'd5: w_match = (DEVICETYPE != 0) &&
                      (w_link == i_link_num) && (w_lane != PAD) && (w_id == TS1);
      4'd6, 4'd7: w_match = (w_link == i_link_num) && (w_lane == i_lane_num) &&
                            (w_id == ((DEVICETYPE == 0) ? TS1 : TS2));
      4'd8: begin
        w_match = (w_link == i_link_num) && (w_lane == i_lane_num) && (w_id == TS2);
        w_chk8  = 1'b1;
      end
      4'd9: w_match = (w_sym0 == 8'h00);
      default: w_in_range = 1'b0;
    endcase
  end

  // An empty history makes the first set after entering substate 8 consistent.
  assign w_cons_ok = !r_hist_vld || ((w_rate == r_rate) && (w_up == r_up));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                  r_cnt <= '0;
    else if (!i_enable || i_sub_chg || !w_in_range) r_cnt <= '0;
    else if (i_valid) begin
      if (!w_match)                   r_cnt <= '0;
      else if (w_chk8 && !w_cons_ok)  r_cnt <= CNT_W'(1);
      else if (r_cnt != '1)           r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rate     <= '0;
      r_up       <= 1'b0;
      r_hist_vld <= 1'b0;
    end else if (!i_enable || i_sub_chg) begin
      r_hist_vld <= 1'b0;
    end else if (i_valid) begin
      r_rate     <= w_rate;
      r_up       <= w_up;
      r_hist_vld <= 1'b1;
    end
  end

  assign o_cnt = r_cnt;

`ifdef OSC_MISMATCH_STATS_EN
  logic [7:0] r_mism;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         r_mism <= '0;
    else if (i_sub_chg) r_mism <= '0;
    else if (i_enable && i_valid && w_in_range &&
             (!w_match || (w_chk8 && !w_cons_ok)) && (r_mism != 8'hFF))
      r_mism <= r_mism + 8'd1;
  end
  assign o_mism = r_mism;
`else
  assign o_mism = '0;
`endif
endmodule

module os_checker_multilane #(
  parameter int LANES      = 4,
  parameter int DEVICETYPE = 0,
  parameter int CNT_W      = 5,
  parameter int REQ_COUNT  = 8
) (
  input logic              clk,
  input logic              reset,
  os_checker_multilane_if.slave bus
);
  logic [3:0]                  r_sub_q;
  logic                        w_sub_chg;
  logic [LANES-1:0][CNT_W-1:0] w_cnt;
  logic [LANES-1:0][7:0]       w_mism;
  logic [LANES-1:0]            w_done;
  logic [7:0]                  r_rateid, w_sel_rate;
  logic                        r_up, w_sel_up;

  assign w_sub_chg = (bus.substate != r_sub_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_sub_q <= '0;
    else        r_sub_q <= bus.substate;
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    os_checker_lane #(.DEVICETYPE(DEVICETYPE), .CNT_W(CNT_W)) u_lane (
      .clk        (clk),
      .reset      (reset),
      .i_substate (bus.substate),
      .i_sub_chg  (w_sub_chg),
      .i_link_num (bus.linkNumber),
      .i_lane_num (bus.laneNumbers[gi]),
      .i_os       (bus.orderedset[gi]),
      .i_valid    (bus.valid[gi]),
      .i_enable   (bus.lane_enable[gi]),
      .o_cnt      (w_cnt[gi]),
      .o_mism     (w_mism[gi])
    );
    assign w_done[gi] = (w_cnt[gi] >= CNT_W'(REQ_COUNT));
  end

  // Lowest-index valid enabled lane wins; scan downward so it is assigned last.
  always_comb begin
    w_sel_rate = r_rateid;
    w_sel_up   = r_up;
    for (int i = LANES - 1; i >= 0; i--) begin
      if (bus.valid[i] && bus.lane_enable[i]) begin
        w_sel_rate = bus.orderedset[i][39:32];
        w_sel_up   = bus.orderedset[i][42];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rateid <= '0;
      r_up     <= 1'b0;
    end else begin
      r_rateid <= w_sel_rate;
      r_up     <= w_sel_up;
    end
  end

  assign bus.lane_cnt               = w_cnt;
  assign bus.lane_done              = w_done;
  assign bus.all_done               = (&(w_done | ~bus.lane_enable)) & (|bus.lane_enable);
  assign bus.rateid                 = r_rateid;
  assign bus.upconfigure_capability = r_up;
  assign bus.mismatch_cnt           = w_mism;
endmodule
